// File: rtl/stuff_or_data_pkg.sv
// Shared types and limits for the multi-lane stuff/data slot distributor.
package stuff_or_data_pkg;

  localparam int SOD_MAX_LANES = 8;

  typedef enum logic {
    SOD_SPREAD     = 1'b0,
    SOD_DATA_FIRST = 1'b1
  } sod_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } sod_state_e;

endpackage

// File: rtl/sod_acc_step.sv
// One slot decision: Bresenham-style accumulator step for spread mode,
// simple threshold on the slot number for data-first mode.
import stuff_or_data_pkg::*;

module sod_acc_step #(
  parameter int MPT_W = 8
) (
  input  logic [MPT_W-1:0] acc,
  input  logic [MPT_W-1:0] cm,
  input  logic [MPT_W-1:0] pm,
  input  sod_mode_e        mode,
  input  logic [MPT_W:0]   j,
  output logic             ds,
  output logic [MPT_W-1:0] acc_next
);

  logic [MPT_W:0] s;
  logic           wrap;

  always_comb begin
    s    = {1'b0, acc} + {1'b0, cm};
    wrap = (s >= {1'b0, pm});
    // acc stays below pm, so the remainder always fits back into MPT_W bits
    acc_next = wrap ? MPT_W'(s - {1'b0, pm}) : MPT_W'(s);
    if (mode == SOD_DATA_FIRST) ds = (j <= {1'b0, cm});
    else                        ds = wrap;
  end

endmodule

// File: rtl/stuff_or_data_mc.sv
// Frame-level stuff/data distributor: decides LANES consecutive slots per
// accepted beat, owns the frame FSM, config registers and sticky flags.
import stuff_or_data_pkg::*;

module stuff_or_data_mc #(
  parameter int MPT_W = 8,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MPT_W-1:0] pm,
  input  logic [MPT_W-1:0] cm,
  input  logic             mode,
  input  logic             sof,
  input  logic             valid_in,
  output logic             sof_out,
  output logic             valid_out,
  output logic             eof_out,
  output logic [LANES-1:0] lane_vld,
  output logic [LANES-1:0] ds,
  output logic [MPT_W-1:0] slot_idx,
  output logic             cfg_err,
  output logic             overrun
);

  localparam int CW = MPT_W + 1;

  sod_state_e       state, state_nxt;
  logic [MPT_W-1:0] pm_r, cm_r, acc_r;
  sod_mode_e        mode_r;
  logic [CW-1:0]    j_r;

  logic [MPT_W-1:0] pm_e, cm_e, acc_e;
  sod_mode_e        mode_e;
  logic [CW-1:0]    j_e, last_slot;
  logic [MPT_W-1:0] acc_chain [LANES+1];
  logic [CW-1:0]    j_lane [LANES];
  logic [LANES-1:0] step_ds, in_frame;
  logic             cfg_bad, eof_beat, beat, load, cfg_nxt, ovr_nxt;

  // A sof beat decides slots 1..LANES of the new frame with the fresh config.
  always_comb begin
    pm_e   = sof ? pm : pm_r;
    cm_e   = sof ? cm : cm_r;
    mode_e = sof ? sod_mode_e'(mode) : mode_r;
    acc_e  = sof ? '0 : acc_r;
    j_e    = sof ? CW'(1) : j_r;
  end

  assign acc_chain[0] = acc_e;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign j_lane[k]   = j_e + CW'(k);
    assign in_frame[k] = (j_lane[k] <= {1'b0, pm_e});
    sod_acc_step #(.MPT_W(MPT_W)) u_step (
      .acc      (acc_chain[k]),
      .cm       (cm_e),
      .pm       (pm_e),
      .mode     (mode_e),
      .j        (j_lane[k]),
      .ds       (step_ds[k]),
      .acc_next (acc_chain[k+1])
    );
  end

  assign last_slot = j_e + CW'(LANES - 1);
  assign eof_beat  = (last_slot >= {1'b0, pm_e});
  assign cfg_bad   = (pm == '0) || (cm > pm);

  always_comb begin
    state_nxt = state;
    beat      = 1'b0;
    load      = 1'b0;
    cfg_nxt   = cfg_err;
    ovr_nxt   = overrun;
    if (sof) begin
      ovr_nxt = 1'b0;
      if (cfg_bad) begin
        cfg_nxt   = 1'b1;
        state_nxt = ERR;
      end else begin
        cfg_nxt   = 1'b0;
        load      = 1'b1;
        state_nxt = RUN;
        if (valid_in) begin
          beat = 1'b1;
          if (eof_beat) state_nxt = DONE;
        end
      end
    end else begin
      case (state)
        RUN: begin
          if (valid_in) begin
            beat = 1'b1;
            if (eof_beat) state_nxt = DONE;
          end
        end
        DONE:    if (valid_in) ovr_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_r      <= '0;
      cm_r      <= '0;
      mode_r    <= SOD_SPREAD;
      acc_r     <= '0;
      j_r       <= '0;
      sof_out   <= 1'b0;
      valid_out <= 1'b0;
      eof_out   <= 1'b0;
      lane_vld  <= '0;
      ds        <= '0;
      slot_idx  <= '0;
      cfg_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sof_out   <= sof;
      valid_out <= beat;
      eof_out   <= beat & eof_beat;
      lane_vld  <= beat ? in_frame : '0;
      ds        <= beat ? (step_ds & in_frame) : '0;
      slot_idx  <= beat ? j_e[MPT_W-1:0] : '0;
      cfg_err   <= cfg_nxt;
      overrun   <= ovr_nxt;
      if (load) begin
        pm_r   <= pm;
        cm_r   <= cm;
        mode_r <= sod_mode_e'(mode);
      end
      if (load || beat) begin
        acc_r <= beat ? acc_chain[LANES] : '0;
        j_r   <= beat ? (j_e + CW'(LANES)) : CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_stuff_or_data_mc.sv
// Directed and random checks of stuff_or_data_mc with LANES=1 and LANES=4
// instances sharing one stimulus stream.
module tb_stuff_or_data_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pm, cm;
  logic       mode, sof, valid_in;

  logic       sof_out1, valid_out1, eof_out1, cfg_err1, overrun1;
  logic [0:0] lane_vld1, ds1;
  logic [7:0] slot_idx1;

  logic       sof_out4, valid_out4, eof_out4, cfg_err4, overrun4;
  logic [3:0] lane_vld4, ds4;
  logic [7:0] slot_idx4;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  stuff_or_data_mc #(.MPT_W(8), .LANES(1)) u1 (
    .clk(clk), .rst(rst), .pm(pm), .cm(cm), .mode(mode), .sof(sof), .valid_in(valid_in),
    .sof_out(sof_out1), .valid_out(valid_out1), .eof_out(eof_out1), .lane_vld(lane_vld1),
    .ds(ds1), .slot_idx(slot_idx1), .cfg_err(cfg_err1), .overrun(overrun1)
  );

  stuff_or_data_mc #(.MPT_W(8), .LANES(4)) u4 (
    .clk(clk), .rst(rst), .pm(pm), .cm(cm), .mode(mode), .sof(sof), .valid_in(valid_in),
    .sof_out(sof_out4), .valid_out(valid_out4), .eof_out(eof_out4), .lane_vld(lane_vld4),
    .ds(ds4), .slot_idx(slot_idx4), .cfg_err(cfg_err4), .overrun(overrun4)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pm = '0; cm = '0; mode = 1'b0; sof = 1'b0; valid_in = 1'b0;
    cycle(); cycle();
    n_total++; if (valid_out1 !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_out1); else n_pass++;
    n_total++; if (sof_out1 !== 1'b0) $display("FAIL reset_sof_out got=%b exp=0", sof_out1); else n_pass++;
    n_total++; if (cfg_err1 !== 1'b0 || overrun1 !== 1'b0) $display("FAIL reset_flags got=%b%b exp=00", cfg_err1, overrun1); else n_pass++;
    n_total++; if (slot_idx1 !== 8'd0 || ds1 !== 1'b0) $display("FAIL reset_slot_ds got=%0d/%b exp=0/0", slot_idx1, ds1); else n_pass++;
    n_total++; if (lane_vld4 !== 4'b0 || eof_out4 !== 1'b0) $display("FAIL reset_l4 got=%b/%b exp=0000/0", lane_vld4, eof_out4); else n_pass++;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_spread();
    logic [4:0] exp_ds;
    exp_ds = 5'b10100;
    pm = 8'd5; cm = 8'd2; mode = 1'b0; sof = 1'b1; valid_in = 1'b0;
    cycle();
    sof = 1'b0;
    n_total++; if (sof_out1 !== 1'b1 || valid_out1 !== 1'b0) $display("FAIL spread_sof got=%b/%b exp=1/0", sof_out1, valid_out1); else n_pass++;
    valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_total++; if (valid_out1 !== 1'b1) $display("FAIL spread_l1_valid beat=%0d got=%b exp=1", i, valid_out1); else n_pass++;
      n_total++; if (ds1[0] !== exp_ds[i]) $display("FAIL spread_l1_ds beat=%0d got=%b exp=%b", i, ds1[0], exp_ds[i]); else n_pass++;
      n_total++; if (slot_idx1 !== 8'(i + 1)) $display("FAIL spread_l1_slot beat=%0d got=%0d exp=%0d", i, slot_idx1, i + 1); else n_pass++;
      n_total++; if (eof_out1 !== (i == 4)) $display("FAIL spread_l1_eof beat=%0d got=%b exp=%b", i, eof_out1, (i == 4)); else n_pass++;
      if (i == 0) begin
        n_total++; if (ds4 !== 4'b0100 || lane_vld4 !== 4'b1111) $display("FAIL spread_l4_b1 got=%b/%b exp=0100/1111", ds4, lane_vld4); else n_pass++;
        n_total++; if (eof_out4 !== 1'b0 || slot_idx4 !== 8'd1) $display("FAIL spread_l4_b1_eof got=%b/%0d exp=0/1", eof_out4, slot_idx4); else n_pass++;
      end
      if (i == 1) begin
        n_total++; if (ds4 !== 4'b0001 || lane_vld4 !== 4'b0001) $display("FAIL spread_l4_b2 got=%b/%b exp=0001/0001", ds4, lane_vld4); else n_pass++;
        n_total++; if (eof_out4 !== 1'b1 || slot_idx4 !== 8'd5) $display("FAIL spread_l4_b2_eof got=%b/%0d exp=1/5", eof_out4, slot_idx4); else n_pass++;
      end
      if (i == 2) begin
        n_total++; if (valid_out4 !== 1'b0 || overrun4 !== 1'b1) $display("FAIL spread_l4_overrun got=%b/%b exp=0/1", valid_out4, overrun4); else n_pass++;
      end
    end
    valid_in = 1'b0;
    cycle();
  endtask

  task automatic test_data_first();
    logic [4:0] exp_ds;
    int gap;
    exp_ds = 5'b00011;
    pm = 8'd5; cm = 8'd2; mode = 1'b1; sof = 1'b1; valid_in = 1'b0;
    cycle();
    sof = 1'b0; valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_total++; if (ds1[0] !== exp_ds[i] || valid_out1 !== 1'b1) $display("FAIL dfirst_ds beat=%0d got=%b/%b exp=%b/1", i, ds1[0], valid_out1, exp_ds[i]); else n_pass++;
      if (i == 0) begin
        n_total++; if (ds4 !== 4'b0011 || lane_vld4 !== 4'b1111) $display("FAIL dfirst_l4_b1 got=%b/%b exp=0011/1111", ds4, lane_vld4); else n_pass++;
      end
      if (i == 1) begin
        n_total++; if (ds4 !== 4'b0000 || lane_vld4 !== 4'b0001 || eof_out4 !== 1'b1) $display("FAIL dfirst_l4_b2 got=%b/%b/%b exp=0000/0001/1", ds4, lane_vld4, eof_out4); else n_pass++;
      end
    end
    // same frame again with idle gaps between beats
    sof = 1'b1; valid_in = 1'b0;
    cycle();
    sof = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gap = $urandom_range(1, 3);
      valid_in = 1'b0;
      for (int g = 0; g < gap; g++) begin
        cycle();
        n_total++; if (valid_out1 !== 1'b0 || ds1 !== 1'b0 || lane_vld1 !== 1'b0) $display("FAIL dfirst_gap slot=%0d got=%b/%b/%b exp=0/0/0", i + 1, valid_out1, ds1, lane_vld1); else n_pass++;
      end
      valid_in = 1'b1;
      cycle();
      n_total++; if (ds1[0] !== exp_ds[i] || slot_idx1 !== 8'(i + 1) || valid_out1 !== 1'b1) $display("FAIL dfirst_gap_ds slot=%0d got=%b/%0d/%b exp=%b/%0d/1", i + 1, ds1[0], slot_idx1, valid_out1, exp_ds[i], i + 1); else n_pass++;
    end
    n_total++; if (eof_out1 !== 1'b1) $display("FAIL dfirst_gap_eof got=%b exp=1", eof_out1); else n_pass++;
    valid_in = 1'b0;
    cycle();
  endtask

  task automatic test_cfg_err();
    pm = 8'd3; cm = 8'd4; mode = 1'b0; sof = 1'b1; valid_in = 1'b0;
    cycle();
    sof = 1'b0;
    n_total++; if (cfg_err1 !== 1'b1 || cfg_err4 !== 1'b1) $display("FAIL cfg_err_set got=%b/%b exp=1/1", cfg_err1, cfg_err4); else n_pass++;
    valid_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_total++; if (valid_out1 !== 1'b0 || valid_out4 !== 1'b0 || cfg_err1 !== 1'b1) $display("FAIL cfg_err_ignore beat=%0d got=%b/%b/%b exp=0/0/1", i, valid_out1, valid_out4, cfg_err1); else n_pass++;
    end
    pm = 8'd3; cm = 8'd3; sof = 1'b1; valid_in = 1'b0;
    cycle();
    sof = 1'b0;
    n_total++; if (cfg_err1 !== 1'b0) $display("FAIL cfg_err_clear got=%b exp=0", cfg_err1); else n_pass++;
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_total++; if (ds1 !== 1'b1 || valid_out1 !== 1'b1 || eof_out1 !== (i == 2)) $display("FAIL cfg_full_data beat=%0d got=%b/%b/%b exp=1/1/%b", i, ds1, valid_out1, eof_out1, (i == 2)); else n_pass++;
      if (i == 0) begin
        n_total++; if (ds4 !== 4'b0111 || lane_vld4 !== 4'b0111 || eof_out4 !== 1'b1) $display("FAIL cfg_full_l4 got=%b/%b/%b exp=0111/0111/1", ds4, lane_vld4, eof_out4); else n_pass++;
      end
    end
    pm = 8'd0; cm = 8'd0; sof = 1'b1; valid_in = 1'b0;
    cycle();
    sof = 1'b0;
    n_total++; if (cfg_err1 !== 1'b1) $display("FAIL cfg_err_pm0 got=%b exp=1", cfg_err1); else n_pass++;
    cycle();
  endtask

  task automatic test_overrun_sof_valid();
    pm = 8'd5; cm = 8'd2; mode = 1'b0; sof = 1'b1; valid_in = 1'b0;
    cycle();
    sof = 1'b0; valid_in = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    n_total++; if (eof_out1 !== 1'b1 || overrun1 !== 1'b0) $display("FAIL ovr_frame_end got=%b/%b exp=1/0", eof_out1, overrun1); else n_pass++;
    cycle();
    n_total++; if (overrun1 !== 1'b1 || valid_out1 !== 1'b0) $display("FAIL ovr_set got=%b/%b exp=1/0", overrun1, valid_out1); else n_pass++;
    pm = 8'd4; cm = 8'd1; sof = 1'b1; valid_in = 1'b1;
    cycle();
    sof = 1'b0;
    n_total++; if (overrun1 !== 1'b0 || sof_out1 !== 1'b1 || valid_out1 !== 1'b1) $display("FAIL sofv_flags got=%b/%b/%b exp=0/1/1", overrun1, sof_out1, valid_out1); else n_pass++;
    n_total++; if (ds1 !== 1'b0 || slot_idx1 !== 8'd1) $display("FAIL sofv_ds got=%b/%0d exp=0/1", ds1, slot_idx1); else n_pass++;
    n_total++; if (ds4 !== 4'b1000 || lane_vld4 !== 4'b1111 || eof_out4 !== 1'b1) $display("FAIL sofv_l4 got=%b/%b/%b exp=1000/1111/1", ds4, lane_vld4, eof_out4); else n_pass++;
    cycle();
    n_total++; if (valid_out1 !== 1'b1 || slot_idx1 !== 8'd2 || overrun4 !== 1'b1) $display("FAIL sofv_beat2 got=%b/%0d/%b exp=1/2/1", valid_out1, slot_idx1, overrun4); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (valid_out1 !== 1'b0 || slot_idx1 !== 8'd0 || overrun4 !== 1'b0) $display("FAIL async_rst got=%b/%0d/%b exp=0/0/0", valid_out1, slot_idx1, overrun4); else n_pass++;
    valid_in = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    int p, c, s, nb4;
    logic exp1;
    logic [3:0] e_ds4, e_vld4;
    for (int f = 0; f < 100; f++) begin
      p = $urandom_range(2, 255);
      c = $urandom_range(2, p);
      pm = 8'(p); cm = 8'(c); mode = 1'b0; sof = 1'b1; valid_in = 1'b0;
      cycle();
      sof = 1'b0; valid_in = 1'b1;
      nb4 = (p + 3) / 4;
      for (int j = 1; j <= p; j++) begin
        cycle();
        exp1 = ((j * c) % p) < c;
        n_total++; if (ds1[0] !== exp1 || valid_out1 !== 1'b1) $display("FAIL rand_l1 pm=%0d cm=%0d j=%0d got=%b/%b exp=%b/1", p, c, j, ds1[0], valid_out1, exp1); else n_pass++;
        if (j <= nb4) begin
          e_ds4 = '0; e_vld4 = '0;
          for (int k = 0; k < 4; k++) begin
            s = 4 * (j - 1) + k + 1;
            if (s <= p) begin
              e_vld4[k] = 1'b1;
              e_ds4[k] = ((s * c) % p) < c;
            end
          end
          n_total++; if (ds4 !== e_ds4 || lane_vld4 !== e_vld4) $display("FAIL rand_l4 pm=%0d cm=%0d beat=%0d got=%b/%b exp=%b/%b", p, c, j, ds4, lane_vld4, e_ds4, e_vld4); else n_pass++;
        end
      end
      valid_in = 1'b0;
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_spread();
    test_data_first();
    test_cfg_err();
    test_overrun_sof_valid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
